// File: rtl/tx_serializer_pkg.sv
// tx_serializer_pkg
//   Shared definitions for the fibre-link TX serializer and the RX-side
//   BER checker: framing state encoding, frame geometry, PRBS7 taps and a
//   one-step LFSR helper.
package tx_serializer_pkg;

  // Framing FSM encoding kept as explicit constants so the codes stay
  // identical to the legacy netlist.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_PRBS  = 3'd4;

  localparam int unsigned FRAME_DATA_BITS = 8;

  // PRBS7: x^7 + x^6 + 1, feedback from bits 6 and 5 shifted in at the LSB.
  localparam int unsigned PRBS7_WIDTH  = 7;
  localparam int unsigned PRBS7_TAP_HI = 6;
  localparam int unsigned PRBS7_TAP_LO = 5;

  function automatic logic [PRBS7_WIDTH-1:0] prbs7_step(
    input logic [PRBS7_WIDTH-1:0] s
  );
    return {s[PRBS7_WIDTH-2:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
  endfunction

endpackage

// File: rtl/tx_serializer_if.sv
// tx_serializer_if
//   Read side of the first-word-fall-through TX FIFO as seen by the
//   serializer.
//     d_in        : FIFO head word, valid while d_in_valid = 1
//     d_in_valid  : FIFO not empty
//     read_enable : pop strobe, one cycle per byte consumed
//   master = FIFO side, slave = serializer side.
interface tx_serializer_if import tx_serializer_pkg::*; ();

  logic [FRAME_DATA_BITS-1:0] d_in;
  logic                       d_in_valid;
  logic                       read_enable;

  modport master (
    output d_in,
    output d_in_valid,
    input  read_enable
  );

  modport slave (
    input  d_in,
    input  d_in_valid,
    output read_enable
  );

endinterface

// File: rtl/prbs7_gen.sv
// prbs7_gen
//   7-bit Fibonacci LFSR for PRBS7 (x^7 + x^6 + 1). Shared with the RX BER
//   checker.
//     clk     : clock
//     rst     : asynchronous active-high reset, loads SEED
//     load    : synchronous reload with SEED (wins over advance)
//     advance : step the LFSR one position
//     bit_out : current sequence bit (LFSR MSB)
module prbs7_gen import tx_serializer_pkg::*; #(
  parameter logic [PRBS7_WIDTH-1:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  output logic bit_out
);

  logic [PRBS7_WIDTH-1:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= prbs7_step(lfsr);
    end
  end

  assign bit_out = lfsr[PRBS7_WIDTH-1];

endmodule

// File: rtl/tx_serializer.sv
// tx_serializer
//   Line-side transmit stage. Pops bytes from the TX FIFO and sends each as
//   an async frame (start 0, 8 data bits LSB first, STOP_BITS stop 1s) one
//   bit per clk_bit cycle; the line idles high. prbs_on replaces framing
//   with a PRBS7 stream for BER testing.
//     clk_bit : bit clock
//     rst     : asynchronous active-high reset
//     fifo    : FIFO read port (d_in, d_in_valid in; read_enable out)
//     prbs_on : PRBS7 test mode request, synchronous to clk_bit
//     out     : registered serial line
//     idle    : registered, 1 when neither framing nor sending PRBS
//   Parameters: STOP_BITS (1..4), PRBS_SEED (non-zero).
module tx_serializer import tx_serializer_pkg::*; #(
  parameter int unsigned            STOP_BITS = 1,
  parameter logic [PRBS7_WIDTH-1:0] PRBS_SEED = 7'h7F
) (
  input  logic                  clk_bit,
  input  logic                  rst,
  tx_serializer_if.slave        fifo,
  input  logic                  prbs_on,
  output logic                  out,
  output logic                  idle
);

  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_DATA_BITS);
  localparam int unsigned STOP_CNT_W = 2;

  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(FRAME_DATA_BITS - 1);
  localparam logic [STOP_CNT_W-1:0] STOP_LAST = STOP_CNT_W'(STOP_BITS - 1);

  state_t                     state, state_n;
  logic [FRAME_DATA_BITS-1:0] shreg, shreg_n;
  logic [BIT_CNT_W-1:0]       bit_cnt, bit_cnt_n;
  logic [STOP_CNT_W-1:0]      stop_cnt, stop_cnt_n;
  logic                       out_n;

  logic launch_point;
  logic take_byte;
  logic prbs_adv;
  logic prbs_load;
  logic prbs_bit;

  // IDLE and the last stop cycle make the same launch decision, which is
  // what gives gap-free back-to-back frames.
  assign launch_point = (state == ST_IDLE) ||
                        ((state == ST_STOP) && (stop_cnt == STOP_LAST));

  assign take_byte        = launch_point && !prbs_on && fifo.d_in_valid;
  assign fifo.read_enable = take_byte && !rst;

  // The LFSR is held at the seed whenever it is not stepping, so on entry
  // its MSB already is the first sequence bit and can be registered onto
  // the line on the entry edge while the LFSR takes its first step. This
  // is equivalent to reloading the seed at every entry.
  assign prbs_adv  = prbs_on && (launch_point || (state == ST_PRBS));
  assign prbs_load = !prbs_adv;

  prbs7_gen #(
    .SEED (PRBS_SEED)
  ) u_prbs7_gen (
    .clk     (clk_bit),
    .rst     (rst),
    .load    (prbs_load),
    .advance (prbs_adv),
    .bit_out (prbs_bit)
  );

  // Next-state logic; out_n is the line value for the cycle after the edge.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    out_n      = 1'b1;

    if (launch_point) begin
      if (prbs_on) begin
        state_n = ST_PRBS;
        out_n   = prbs_bit;
      end else if (fifo.d_in_valid) begin
        state_n = ST_START;
        shreg_n = fifo.d_in;
        out_n   = 1'b0;
      end else begin
        state_n = ST_IDLE;
      end
    end else begin
      case (state)
        ST_START: begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
          out_n     = shreg[0];
          shreg_n   = shreg >> 1;
        end
        ST_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            state_n    = ST_STOP;
            stop_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            out_n     = shreg[0];
            shreg_n   = shreg >> 1;
          end
        end
        ST_STOP: begin
          stop_cnt_n = stop_cnt + 1'b1;
        end
        ST_PRBS: begin
          if (prbs_on) begin
            out_n = prbs_bit;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_bit or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      out      <= 1'b1;
      idle     <= 1'b1;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      out      <= out_n;
      idle     <= (state_n == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer
//   Directed bench for tx_serializer: one instance with STOP_BITS = 1 and
//   one with STOP_BITS = 3, each fed by a queue-backed FWFT FIFO model.
//   Frame expectations are written as {stop bits, data byte, start bit} so
//   that sample k of a frame is bit k of the vector.
module tb_tx_serializer;

  logic clk = 1'b0;
  logic rst;
  logic prbs_on;
  logic prbs3;

  always #5 clk = ~clk;

  tx_serializer_if if1 ();
  tx_serializer_if if3 ();

  logic out1, idle1, out3, idle3;

  tx_serializer #(.STOP_BITS(1), .PRBS_SEED(7'h7F)) dut1 (
    .clk_bit (clk),
    .rst     (rst),
    .fifo    (if1),
    .prbs_on (prbs_on),
    .out     (out1),
    .idle    (idle1)
  );

  tx_serializer #(.STOP_BITS(3), .PRBS_SEED(7'h7F)) dut3 (
    .clk_bit (clk),
    .rst     (rst),
    .fifo    (if3),
    .prbs_on (prbs3),
    .out     (out3),
    .idle    (idle3)
  );

  int n_cmp = 0;
  int n_err = 0;
  int spurious = 0;

  logic [7:0] q1[$];
  logic [7:0] q3[$];

  logic s_out1, s_re1, s_idle1, s_out3, s_re3, s_idle3;

  logic        ps [0:253];
  logic [31:0] v;
  logic [13:0] head;
  int          re_n, re_idx, idle_hi, ones, mism;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_drive();
    if1.d_in       = (q1.size() != 0) ? q1[0] : 8'h00;
    if1.d_in_valid = (q1.size() != 0);
    if3.d_in       = (q3.size() != 0) ? q3[0] : 8'h00;
    if3.d_in_valid = (q3.size() != 0);
  endtask

  // Sample one cycle's outputs at the falling edge, then let the FIFO
  // model retire a popped word just after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_out1  = out1;
    s_re1   = if1.read_enable;
    s_idle1 = idle1;
    s_out3  = out3;
    s_re3   = if3.read_enable;
    s_idle3 = idle3;
    if (s_re1 && !if1.d_in_valid) spurious++;
    if (s_re3 && !if3.d_in_valid) spurious++;
    @(posedge clk);
    #1;
    if (s_re1 && q1.size() != 0) q1.delete(0);
    if (s_re3 && q3.size() != 0) q3.delete(0);
    fifo_drive();
  endtask

  task automatic find_pop(input string tag, input bit sel3);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sel3 ? s_re3 : s_re1) break;
    end
    check_eq(tag, sel3 ? s_re3 : s_re1, 1);
  endtask

  task automatic grab1(input int n, output logic [31:0] vec);
    vec = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      vec[k] = s_out1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    prbs_on = 1'b0;
    prbs3   = 1'b0;
    q1.push_back(8'hA5);
    fifo_drive();

    // Reset held with a word waiting.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_out", s_out1, 1);
      check_eq("rst_idle", s_idle1, 1);
      check_eq("rst_re", s_re1, 0);
    end
    check_eq("rst_nopop", q1.size(), 1);
    rst = 1'b0;

    // Single byte A5.
    find_pop("a5_pop", 1'b0);
    check_eq("a5_idle_at_pop", s_idle1, 1);
    re_n = 0;
    v = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      v[k] = s_out1;
      re_n += int'(s_re1);
      if (k == 0) check_eq("a5_idle_busy", s_idle1, 0);
    end
    check_eq("a5_frame", v[9:0], {1'b1, 8'hA5, 1'b0});
    tick();
    check_eq("a5_after_out", s_out1, 1);
    check_eq("a5_after_idle", s_idle1, 1);
    re_n += int'(s_re1);
    tick();
    check_eq("a5_hold_out", s_out1, 1);
    re_n += int'(s_re1);
    check_eq("a5_single_pop", re_n, 0);

    // Back-to-back 00 then FF.
    q1.push_back(8'h00);
    q1.push_back(8'hFF);
    fifo_drive();
    find_pop("b2b_pop", 1'b0);
    re_n = 0; re_idx = -1; idle_hi = 0; v = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      v[k] = s_out1;
      idle_hi += int'(s_idle1);
      if (s_re1) begin
        re_n++;
        re_idx = k;
      end
    end
    check_eq("b2b_frames", v[19:0], {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0});
    check_eq("b2b_pop_count", re_n, 1);
    check_eq("b2b_pop_spacing", re_idx + 1, 10);
    check_eq("b2b_no_gap", idle_hi, 0);

    // STOP_BITS = 3 instance, byte 0F.
    q3.push_back(8'h0F);
    fifo_drive();
    find_pop("s3_pop", 1'b1);
    v = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      v[k] = s_out3;
    end
    check_eq("s3_frame", v[11:0], {3'b111, 8'h0F, 1'b0});
    tick();
    check_eq("s3_after_out", s_out3, 1);
    check_eq("s3_after_idle", s_idle3, 1);

    // PRBS handover at data bit 3 of 3C, with a second byte already waiting.
    q1.push_back(8'h3C);
    q1.push_back(8'h55);
    fifo_drive();
    find_pop("ho_pop", 1'b0);
    re_n = 0; v = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) prbs_on = 1'b1;
      tick();
      v[k] = s_out1;
      re_n += int'(s_re1);
    end
    check_eq("ho_frame", v[9:0], {1'b1, 8'h3C, 1'b0});
    check_eq("ho_prio_re", re_n, 0);
    idle_hi = 0;
    for (int k = 0; k < 254; k++) begin
      tick();
      ps[k] = s_out1;
      re_n += int'(s_re1);
      idle_hi += int'(s_idle1);
    end
    for (int k = 0; k < 14; k++) head[k] = ps[k];
    ones = 0;
    mism = 0;
    for (int k = 0; k < 127; k++) begin
      ones += int'(ps[k]);
      if (ps[k] !== ps[k + 127]) mism++;
    end
    check_eq("prbs_head", head, 14'h207F);
    check_eq("prbs_ones", ones, 64);
    check_eq("prbs_period", mism, 0);
    check_eq("prbs_re", re_n, 0);
    check_eq("prbs_idle", idle_hi, 0);
    check_eq("prbs_fifo_kept", q1.size(), 1);

    prbs_on = 1'b0;
    tick();
    tick();
    check_eq("prbs_exit_out", s_out1, 1);
    check_eq("prbs_exit_idle", s_idle1, 1);
    check_eq("prbs_exit_pop", s_re1, 1);
    grab1(10, v);
    check_eq("ho_next_frame", v[9:0], {1'b1, 8'h55, 1'b0});

    // PRBS entered from IDLE restarts from the seed.
    tick();
    tick();
    prbs_on = 1'b1;
    tick();
    check_eq("prbs2_decide_out", s_out1, 1);
    grab1(14, v);
    check_eq("prbs2_head", v[13:0], 14'h207F);
    prbs_on = 1'b0;
    tick();
    tick();
    check_eq("prbs2_exit_out", s_out1, 1);

    // Reset in the middle of byte 81, at data bit 5.
    q1.push_back(8'h81);
    fifo_drive();
    find_pop("mf_pop", 1'b0);
    for (int k = 0; k < 6; k++) tick();
    check_eq("mf_pre_bit5", out1, 0);
    rst = 1'b1;
    #1;
    check_eq("mf_async_out", out1, 1);
    check_eq("mf_async_idle", idle1, 1);
    check_eq("mf_async_re", if1.read_enable, 0);
    tick();
    tick();
    rst = 1'b0;
    check_eq("mf_byte_lost", q1.size(), 0);
    q1.push_back(8'hC3);
    fifo_drive();
    find_pop("mf_next_pop", 1'b0);
    grab1(10, v);
    check_eq("mf_next_frame", v[9:0], {1'b1, 8'hC3, 1'b0});
    tick();
    check_eq("mf_next_idle", s_idle1, 1);

    check_eq("re_without_valid", spurious, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
